// File: rtl/dcm_lock_monitor.sv
// ---------------------------------------------------------------------------
// dcm_lock_monitor
//   Verifies a DCM/PLL generated clock against its reference. The module runs
//   on the generated clock (clk) and samples ref_clk as asynchronous data.
//   It counts clk cycles over a window of REF_PERIODS reference periods,
//   compares the count with EXPECTED = REF_PERIODS*CLKFX_MULTIPLY/CLKFX_DIVIDE
//   and raises its own lock flag after LOCK_COUNT consecutive good windows.
//
//   Optional build macro: DCM_LOCK_MONITOR_HYST_EN
//     defined   : lock drops only after two consecutive bad windows
//     undefined : any bad window drops lock
//   A reference timeout drops lock in both builds.
//
// Ports
//   clk        in   generated (monitored) clock, sole clock
//   rst        in   asynchronous active-high reset
//   enable     in   0 = idle, window/good/timeout counters cleared
//   ref_clk    in   reference clock, sampled as data
//   locked     out  ratio verified
//   meas_valid out  one-cycle pulse per completed window
//   meas_count out  clk cycles in the last window (held)
//   meas_error out  last window out of tolerance (held)
//   err_count  out  bad windows + timeouts since reset, saturates at 255
// ---------------------------------------------------------------------------
module dcm_lock_monitor #(
    parameter int unsigned CLKFX_MULTIPLY = 4,
    parameter int unsigned CLKFX_DIVIDE   = 1,
    parameter int unsigned REF_PERIODS    = 64,
    parameter int unsigned TOLERANCE      = 2,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned TIMEOUT_CYC    = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ref_clk,
    output logic             locked,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_error,
    output logic [7:0]       err_count
);

    localparam int unsigned EXPECTED = REF_PERIODS * CLKFX_MULTIPLY / CLKFX_DIVIDE;
    localparam int unsigned RC_W     = $clog2(REF_PERIODS + 1);
    localparam int unsigned GC_W     = $clog2(LOCK_COUNT + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXPECTED);
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOLERANCE);
    localparam logic [RC_W-1:0]  RP_LAST = RC_W'(REF_PERIODS - 1);
    localparam logic [GC_W-1:0]  LC_C    = GC_W'(LOCK_COUNT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    state_t           state_q;
    logic [2:0]       ref_sync_q;
    logic [CNT_W-1:0] win_cnt_q;
    logic [RC_W-1:0]  ref_cnt_q;
    logic [GC_W-1:0]  good_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             locked_q;
    logic             meas_valid_q;
    logic [CNT_W-1:0] meas_count_q;
    logic             meas_error_q;
    logic [7:0]       err_cnt_q;
`ifdef DCM_LOCK_MONITOR_HYST_EN
    logic             bad_streak_q;
`endif

    logic             ref_rise;
    logic [CNT_W-1:0] win_cnt_d;
    logic [GC_W-1:0]  good_cnt_d;
    logic [7:0]       err_cnt_d;
    logic [CNT_W-1:0] win_diff;
    logic             win_bad;
    logic             timeout;

    // ref_sync_q[1:0] is the synchronizer, [2] the delayed copy for edge detect
    assign ref_rise = ref_sync_q[1] & ~ref_sync_q[2];
    assign timeout  = ~ref_rise && (to_cnt_q == TO_LAST);

    always_comb begin
        win_cnt_d  = (&win_cnt_q) ? win_cnt_q : win_cnt_q + 1'b1;
        good_cnt_d = (good_cnt_q == LC_C) ? good_cnt_q : good_cnt_q + 1'b1;
        err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 8'd1;
        win_diff   = (win_cnt_q >= EXP_C) ? (win_cnt_q - EXP_C) : (EXP_C - win_cnt_q);
        // a saturated count is meaningless, so it is always bad
        win_bad    = (&win_cnt_q) || (win_diff > TOL_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ref_sync_q   <= '0;
            win_cnt_q    <= '0;
            ref_cnt_q    <= '0;
            good_cnt_q   <= '0;
            to_cnt_q     <= '0;
            locked_q     <= 1'b0;
            meas_valid_q <= 1'b0;
            meas_count_q <= '0;
            meas_error_q <= 1'b0;
            err_cnt_q    <= '0;
`ifdef DCM_LOCK_MONITOR_HYST_EN
            bad_streak_q <= 1'b0;
`endif
        end else begin
            ref_sync_q   <= {ref_sync_q[1:0], ref_clk};
            meas_valid_q <= 1'b0;

            if (!enable) begin
                // enable low overrides everything, including a window close
                state_q    <= ST_IDLE;
                locked_q   <= 1'b0;
                win_cnt_q  <= '0;
                ref_cnt_q  <= '0;
                good_cnt_q <= '0;
                to_cnt_q   <= '0;
`ifdef DCM_LOCK_MONITOR_HYST_EN
                bad_streak_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARM;
                    end

                    ST_ARM: begin
                        if (ref_rise) begin
                            state_q   <= ST_MEASURE;
                            win_cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
                            ref_cnt_q <= '0;
                            to_cnt_q  <= '0;
                        end else if (timeout) begin
                            err_cnt_q <= err_cnt_d;
                            to_cnt_q  <= '0;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end

                    ST_MEASURE, ST_LOCKED: begin
                        if (ref_rise) begin
                            to_cnt_q <= '0;
                            if (ref_cnt_q == RP_LAST) begin
                                // closing edge also opens the next window
                                meas_valid_q <= 1'b1;
                                meas_count_q <= win_cnt_q;
                                meas_error_q <= win_bad;
                                win_cnt_q    <= {{(CNT_W-1){1'b0}}, 1'b1};
                                ref_cnt_q    <= '0;
                                if (win_bad) begin
                                    err_cnt_q <= err_cnt_d;
`ifdef DCM_LOCK_MONITOR_HYST_EN
                                    if (state_q == ST_LOCKED && !bad_streak_q) begin
                                        bad_streak_q <= 1'b1;
                                    end else begin
                                        bad_streak_q <= 1'b0;
                                        good_cnt_q   <= '0;
                                        state_q      <= ST_MEASURE;
                                        locked_q     <= 1'b0;
                                    end
`else
                                    good_cnt_q <= '0;
                                    state_q    <= ST_MEASURE;
                                    locked_q   <= 1'b0;
`endif
                                end else begin
                                    good_cnt_q <= good_cnt_d;
`ifdef DCM_LOCK_MONITOR_HYST_EN
                                    bad_streak_q <= 1'b0;
`endif
                                    if (good_cnt_d == LC_C) begin
                                        state_q  <= ST_LOCKED;
                                        locked_q <= 1'b1;
                                    end
                                end
                            end else begin
                                ref_cnt_q <= ref_cnt_q + 1'b1;
                                win_cnt_q <= win_cnt_d;
                            end
                        end else if (timeout) begin
                            state_q    <= ST_ARM;
                            locked_q   <= 1'b0;
                            good_cnt_q <= '0;
                            err_cnt_q  <= err_cnt_d;
                            to_cnt_q   <= '0;
                            win_cnt_q  <= '0;
                            ref_cnt_q  <= '0;
`ifdef DCM_LOCK_MONITOR_HYST_EN
                            bad_streak_q <= 1'b0;
`endif
                        end else begin
                            to_cnt_q  <= to_cnt_q + 1'b1;
                            win_cnt_q <= win_cnt_d;
                        end
                    end

                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign locked     = locked_q;
    assign meas_valid = meas_valid_q;
    assign meas_count = meas_count_q;
    assign meas_error = meas_error_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_dcm_lock_monitor.sv
// ---------------------------------------------------------------------------
// tb_dcm_lock_monitor
//   Drives ref_clk as a sequence of periods measured in clk cycles and keeps a
//   window-level reference model: each reference rising edge is counted, and
//   every REF_PERIODS edges the summed period lengths form one window whose
//   expected outcome is queued. A monitor pops the queue on each meas_valid.
// ---------------------------------------------------------------------------
module tb_dcm_lock_monitor;

    localparam int EXP_CNT = 256;   // 64 * 4 / 1
    localparam int TOL     = 2;
    localparam int NPER    = 64;
    localparam int LOCK_N  = 4;
    localparam int TO_CYC  = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ref_clk;
    logic        locked;
    logic        meas_valid;
    logic [15:0] meas_count;
    logic        meas_error;
    logic [7:0]  err_count;

    dcm_lock_monitor #(
        .CLKFX_MULTIPLY(4),
        .CLKFX_DIVIDE  (1),
        .REF_PERIODS   (64),
        .TOLERANCE     (2),
        .LOCK_COUNT    (4),
        .TIMEOUT_CYC   (1024),
        .CNT_W         (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ref_clk   (ref_clk),
        .locked    (locked),
        .meas_valid(meas_valid),
        .meas_count(meas_count),
        .meas_error(meas_error),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int err;
        int errc;
        int lk;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    int m_en     = 0;
    int m_open   = 0;
    int m_n      = 0;
    int m_sum    = 0;
    int m_good   = 0;
    int m_errc   = 0;
    int m_streak = 0;
    int m_locked = 0;
    int m_last   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_close(input int s);
        exp_t e;
        int   is_bad;
        is_bad = (s > EXP_CNT + TOL) || (s < EXP_CNT - TOL);
        if (!is_bad) begin
            if (m_good < LOCK_N) m_good++;
            m_streak = 0;
            if (m_good >= LOCK_N) m_locked = 1;
        end else begin
            if (m_errc < 255) m_errc++;
`ifdef DCM_LOCK_MONITOR_HYST_EN
            if (m_locked != 0 && m_streak == 0) begin
                m_streak = 1;
            end else begin
                m_good = 0; m_locked = 0; m_streak = 0;
            end
`else
            m_good = 0; m_locked = 0;
`endif
        end
        m_last = s;
        e.cnt = s; e.err = is_bad; e.errc = m_errc; e.lk = m_locked;
        q.push_back(e);
    endfunction

    // one reference period of p clk cycles, starting with a rising edge
    task automatic ref_period(input int p);
        if (m_en != 0) begin
            if (m_open != 0) begin
                m_n++;
                if (m_n == NPER) begin
                    model_close(m_sum);
                    m_n = 0;
                    m_sum = 0;
                end
            end else begin
                m_open = 1; m_n = 0; m_sum = 0;
            end
            m_sum += p;
        end
        ref_clk = 1'b1;
        repeat (p / 2) @(negedge clk);
        ref_clk = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    // NPER periods of 'base' cycles, total shifted by d, in shuffled order
    task automatic run_window(input int base, input int d);
        int per[NPER];
        int ad;
        int j;
        int t;
        ad = (d < 0) ? -d : d;
        for (int i = 0; i < NPER; i++) per[i] = base;
        for (int k = 0; k < ad; k++) per[k] += (d > 0) ? 1 : -1;
        for (int i = 0; i < NPER; i++) begin
            j = int'($urandom_range(NPER - 1));
            t = per[i]; per[i] = per[j]; per[j] = t;
        end
        for (int i = 0; i < NPER; i++) ref_period(per[i]);
    endtask

    task automatic model_disable();
        m_open = 0; m_good = 0; m_locked = 0; m_streak = 0;
    endtask

    // monitor: every completed window must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            if (q.size() == 0) begin
                check("unexpected_meas_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("meas_count", int'(meas_count), e.cnt);
                check("meas_error", int'(meas_error), e.err);
                check("err_count",  int'(err_count),  e.errc);
                check("locked",     int'(locked),     e.lk);
            end
        end
    end

    initial begin
        #3_000_000;
        check("watchdog_expired", 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int lk_before;
        int d;

        rst = 1'b1; enable = 1'b0; ref_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_locked",     int'(locked),     0);
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_meas_count", int'(meas_count), 0);
        check("rst_meas_error", int'(meas_error), 0);
        check("rst_err_count",  int'(err_count),  0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1; m_en = 1;
        repeat (3) @(negedge clk);

        // ideal 4x: lock at the 4th window
        repeat (6) run_window(4, 0);
        // 5x: every window bad
        repeat (3) run_window(5, 0);
        // tolerance edges, then random offsets
        run_window(4, 2);
        run_window(4, -2);
        run_window(4, 3);
        run_window(4, -3);
        repeat (4) begin
            d = int'($urandom_range(8)) - 4;
            run_window(4, d);
        end
        // lock, then isolated and paired bad windows, then relock
        repeat (4) run_window(4, 0);
        run_window(4, 4);
        run_window(4, 0);
        run_window(4, 4);
        run_window(4, 4);
        repeat (5) run_window(4, 0);

        // reference lost: lock held until the timeout, then dropped
        ref_period(4);
        lk_before = m_locked;
        m_errc = (m_errc < 255) ? m_errc + 1 : 255;
        model_disable();
        repeat (900) @(negedge clk);
        check("locked_before_timeout", int'(locked), lk_before);
        repeat (300) @(negedge clk);
        check("locked_after_timeout", int'(locked), 0);
        repeat (300) @(negedge clk);
        repeat (5) run_window(4, 0);
        ref_period(4);

        // enable drop mid-window
        repeat (10) ref_period(4);
        enable = 1'b0; m_en = 0;
        model_disable();
        @(negedge clk);
        check("en_drop_locked", int'(locked), 0);
        check("en_drop_meas_count_hold", int'(meas_count), m_last);
        repeat (5) @(negedge clk);
        enable = 1'b1; m_en = 1;
        repeat (3) @(negedge clk);
        repeat (5) run_window(4, 0);
        ref_period(4);

        // reset mid-window
        repeat (10) ref_period(4);
        rst = 1'b1;
        model_disable();
        m_errc = 0; m_last = 0;
        @(negedge clk);
        check("midrst_locked",     int'(locked),     0);
        check("midrst_meas_valid", int'(meas_valid), 0);
        check("midrst_meas_count", int'(meas_count), 0);
        check("midrst_meas_error", int'(meas_error), 0);
        check("midrst_err_count",  int'(err_count),  0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        repeat (5) run_window(4, 0);
        ref_period(4);
        repeat (20) @(negedge clk);

        check("final_locked", int'(locked), m_locked);
        check("scoreboard_leftover", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
